// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared depth and occupancy type for the FIFO read-stream adapter
package fifo_rd_stream_pkg;
    localparam int SKID_DEPTH = 2;
    typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf: 2-entry in-order register buffer; head always in slot 0
module fifo_rd_stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] head,
    output occ_t              count
);
    logic [DATA_W-1:0] slot0, slot1;
    occ_t wp;
    assign wp   = count - occ_t'(rd);
    assign head = slot0;
    // pop shifts slot1 forward; a write lands just behind whatever survives the pop
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
        end else begin
            slot0 <= (wr && wp == 2'd0) ? wdata : (rd ? slot1 : slot0);
            slot1 <= (wr && wp == 2'd1) ? wdata : slot1;
            count <= count + occ_t'(wr) - occ_t'(rd);
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read port to valid/ready stream adapter; FIFO_RD_STREAM_STATS_EN adds out_beats
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [15:0]       out_beats
`endif
);
    occ_t count;
    logic inflight, pop;
    assign m_valid = count != 2'd0;
    assign pop     = m_valid && m_ready;
    assign fifo_rd_en = !rst && !fifo_empty &&
        ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'(SKID_DEPTH);
    // a read issued this cycle returns data next cycle, so remember it as in flight
    always_ff @(posedge clk) begin
        inflight <= rst ? 1'b0 : fifo_rd_en;
    end
    fifo_rd_stream_buf #(.DATA_W(DATA_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .wr    (inflight),
        .wdata (fifo_rd_data),
        .rd    (pop),
        .head  (m_data),
        .count (count)
    );
`ifdef FIFO_RD_STREAM_STATS_EN
    // count accepted beats, wrapping at 16 bits
    always_ff @(posedge clk) begin
        out_beats <= rst ? 16'd0 : out_beats + 16'(pop);
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized self-checking bench with a queue-based FIFO and buffer model
module tb_fifo_rd_stream;
    logic       clk = 0;
    logic       rst = 1;
    logic       fifo_empty = 1;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 0;
    logic       m_valid;
    logic       m_ready = 0;
    logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0] out_beats;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .out_beats    (out_beats)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q[$];
    logic [7:0] bq[$];
    bit   minf = 0;
    int   beats = 0;
    int   rd_pulses = 0;
    int   ncyc = 0;
    int   first_rd = -1;
    int   first_v = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        fifo_empty = 0;
    endtask

    task automatic cycle();
        bit exp_valid, pop, exp_rd, act_rd;
        @(negedge clk);
        exp_valid = bq.size() != 0;
        check("m_valid", m_valid, exp_valid);
        if (exp_valid) check("m_data", m_data, bq[0]);
        pop = exp_valid && m_ready;
        exp_rd = !rst && !fifo_empty && (bq.size() + int'(minf) - int'(pop)) < 2;
        check("rd_en", fifo_rd_en, exp_rd);
        check("rd_while_empty", fifo_rd_en && fifo_empty, 0);
        act_rd = fifo_rd_en;
        if (act_rd) rd_pulses++;
        if (act_rd && first_rd < 0) first_rd = ncyc;
        if (m_valid && first_v < 0) first_v = ncyc;
        @(posedge clk);
        if (rst) begin
            bq.delete();
            minf = 0;
            beats = 0;
        end else begin
            if (pop) begin
                void'(bq.pop_front());
                beats++;
            end
            if (minf) bq.push_back(fifo_rd_data);
            minf = exp_rd;
        end
        #1;
        if (act_rd && q.size() != 0) fifo_rd_data = q.pop_front();
        fifo_empty = q.size() == 0;
        ncyc++;
    endtask

    initial begin
        int b0, guard;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_m_data", m_data, 0);
            check("rst_m_valid", m_valid, 0);
        end
        rst = 0;
        first_rd = -1;
        first_v = -1;
        for (int i = 0; i < 12; i++) cycle();
        check("stream_latency", first_v - first_rd, 2);
        check("stream_beats", beats, 8);

        b0 = beats;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        guard = 0;
        while (beats == b0 && guard < 20) begin
            cycle();
            guard++;
        end
        check("bp_first_beat_seen", beats - b0, 1);
        m_ready = 0;
        for (int i = 0; i < 5; i++) cycle();
        check("bp_count", dut.count, 2);
        check("bp_hold", m_data, 8'hA1);
        m_ready = 1;
        for (int i = 0; i < 10; i++) cycle();
        check("bp_beats", beats - b0, 6);

        b0 = beats;
        rd_pulses = 0;
        push(8'h5C);
        for (int i = 0; i < 6; i++) cycle();
        check("single_rd_pulses", rd_pulses, 1);
        check("single_beats", beats - b0, 1);
        check("single_valid_after", m_valid, 0);

        m_ready = 0;
        for (int i = 0; i < 6; i++) push(8'h90 + 8'(i));
        guard = 0;
        while (!(bq.size() == 1 && minf) && guard < 10) begin
            cycle();
            guard++;
        end
        check("pre_rst_count", dut.count, 1);
        check("pre_rst_inflight", dut.inflight, 1);
        rst = 1;
        cycle();
        rst = 0;
        q.delete();
        fifo_empty = 1;
        check("post_rst_valid", m_valid, 0);
        check("post_rst_count", dut.count, 0);
        push(8'h33);
        push(8'h34);
        m_ready = 1;
        for (int i = 0; i < 6; i++) cycle();
        check("post_rst_beats", beats, 2);

        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            cycle();
        end
        m_ready = 1;
        for (int i = 0; i < 40 && (q.size() != 0 || bq.size() != 0 || minf); i++) cycle();
        check("drain_valid", m_valid, 0);
        check("drain_model_empty", bq.size(), 0);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("stats_random", out_beats, 16'(beats));
        rst = 1;
        cycle();
        rst = 0;
        q.delete();
        fifo_empty = 1;
        check("stats_rst", out_beats, 0);
        b0 = 0;
        guard = 0;
        while (beats < 70000 && guard < 70100) begin
            while (q.size() < 4 && b0 < 70000) begin
                push(8'(b0));
                b0++;
            end
            cycle();
            guard++;
        end
        check("stats_beats", beats, 70000);
        check("stats_wrap", out_beats, 4464);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
